// File: rtl/scene_loader.sv
// scene_loader: parses the SPI command byte stream and writes the vertex,
// triangle, instance and transform RAMs. Vertex and triangle regions are
// handed out by bump pointers. A small model table remembers where each
// model was stored. max_inst and create_done are published to frame_driver.
module scene_loader #(
    parameter int MAX_VERT   = 8192,
    parameter int MAX_TRI    = 8192,
    parameter int MAX_MODELS = 16,
    parameter int VTX_W      = 108,
    parameter int VIDX_W     = 8,
    parameter int XF_W       = 288
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [7:0]            in_data,
    output logic                  in_ready,
    output logic                  vert_we,
    output logic [12:0]           vert_waddr,
    output logic [VTX_W-1:0]      vert_wdata,
    output logic                  tri_we,
    output logic [12:0]           tri_waddr,
    output logic [3*VIDX_W-1:0]   tri_wdata,
    output logic                  inst_we,
    output logic [7:0]            inst_waddr,
    output logic [33:0]           inst_wdata,
    output logic                  xf_we,
    output logic [7:0]            xf_waddr,
    output logic [XF_W-1:0]       xf_wdata,
    output logic [7:0]            max_inst,
    output logic                  create_done,
    output logic                  err
);
    localparam int TRI_W     = 3 * VIDX_W;
    localparam int VTX_BYTES = (VTX_W + 7) / 8;
    localparam int TRI_BYTES = (TRI_W + 7) / 8;
    localparam int XF_BYTES  = (XF_W + 7) / 8;
    localparam int SH_BYTES0 = (VTX_BYTES > TRI_BYTES) ? VTX_BYTES : TRI_BYTES;
    localparam int SH_BYTES  = (XF_BYTES > SH_BYTES0) ? XF_BYTES : SH_BYTES0;
    localparam int SH_W      = 8 * SH_BYTES;
    localparam int BI_W      = $clog2(SH_BYTES + 1);
    localparam int MID_W     = $clog2(MAX_MODELS);
    localparam int PTR_W     = 14;
    localparam int DC_W      = 16;

    localparam logic [7:0] OP_LOAD   = 8'hA1;
    localparam logic [7:0] OP_CREATE = 8'hA2;
    localparam logic [7:0] OP_CAMERA = 8'hA3;
    localparam logic [7:0] OP_UPDATE = 8'hA4;
    localparam logic [7:0] OP_COMMIT = 8'hA5;
    localparam logic [7:0] OP_CLEAR  = 8'hA6;

    typedef enum logic [2:0] {S_IDLE, S_HDR, S_PAYLOAD, S_WRITE, S_DISCARD} state_t;
    typedef enum logic [1:0] {C_LOAD, C_CREATE, C_CAMERA, C_UPDATE} cmd_t;
    typedef enum logic [1:0] {SEC_VERT, SEC_TRI, SEC_XF} sect_t;

    state_t             state;
    cmd_t               cmd;
    sect_t              sect;
    logic [1:0]         hdr_cnt;
    logic [7:0]         mid;
    logic [7:0]         vcnt;
    logic [7:0]         tcnt;
    logic [7:0]         target;
    logic [7:0]         word_idx;
    logic [BI_W-1:0]    byte_idx;
    logic [DC_W-1:0]    disc_cnt;
    logic [SH_W-1:0]    shift;
    logic [PTR_W-1:0]   vert_ptr;
    logic [PTR_W-1:0]   tri_ptr;
    logic [8:0]         next_inst;

    // Model table: region bases and triangle count per model id.
    logic [12:0]           tbl_vbase [MAX_MODELS];
    logic [12:0]           tbl_tbase [MAX_MODELS];
    logic [7:0]            tbl_tcnt  [MAX_MODELS];
    logic [MAX_MODELS-1:0] tbl_valid;

    logic [MID_W-1:0]   mid_i;
    logic               accept;
    logic [SH_W-1:0]    shift_next;
    logic [BI_W-1:0]    sect_last;
    logic [7:0]         sect_words;
    logic               word_last;
    logic               tri_bad;
    logic [14:0]        vert_end;
    logic [14:0]        tri_end;
    logic               load_bad;
    logic               create_bad;
    logic               update_bad;
    logic [DC_W-1:0]    load_bytes;
    logic               tbl_we;

    assign mid_i      = mid[MID_W-1:0];
    assign accept     = in_valid && in_ready;
    // Words arrive MSB first, so each new byte enters at the bottom; pad bits
    // of the first byte end up above the word and are simply not taken.
    assign shift_next = {shift[SH_W-9:0], in_data};
    assign word_last  = ({1'b0, word_idx} + 9'd1) == {1'b0, sect_words};
    assign tri_bad    = (shift_next[TRI_W-1 -: VIDX_W] >= vcnt) ||
                        (shift_next[2*VIDX_W-1 -: VIDX_W] >= vcnt) ||
                        (shift_next[VIDX_W-1:0] >= vcnt);

    // LOAD_MODEL header checks, evaluated while tcnt is the byte on in_data.
    assign vert_end   = 15'(vert_ptr) + 15'(vcnt);
    assign tri_end    = 15'(tri_ptr) + 15'(in_data);
    assign load_bad   = (32'(mid) >= 32'(MAX_MODELS)) || (vcnt == 8'd0) || (in_data == 8'd0) ||
                        (vert_end > 15'(MAX_VERT)) || (tri_end > 15'(MAX_TRI));
    assign load_bytes = DC_W'(vcnt) * DC_W'(VTX_BYTES) + DC_W'(in_data) * DC_W'(TRI_BYTES);

    // CREATE_INST / UPDATE_INST checks on the single header byte.
    assign create_bad = (32'(in_data) >= 32'(MAX_MODELS)) ||
                        !tbl_valid[in_data[MID_W-1:0]] || next_inst[8];
    assign update_bad = (in_data == 8'd0) || (in_data > max_inst);

    assign tbl_we     = (state == S_WRITE) && (sect == SEC_TRI) && word_last;

    // Byte length and word count of the section currently being received.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        sect_last  = BI_W'(XF_BYTES - 1);
        sect_words = 8'd1;
        case (sect)
            SEC_VERT: begin
                sect_last  = BI_W'(VTX_BYTES - 1);
                sect_words = vcnt;
            end
            SEC_TRI: begin
                sect_last  = BI_W'(TRI_BYTES - 1);
                sect_words = tcnt;
            end
            default: ;
        endcase
    end

    // Record a model's region when its last triangle is written.
    // NOTE: table payload is not reset; the valid bits alone gate every lookup.
    always_ff @(posedge clk) begin
        if (tbl_we) begin
            tbl_vbase[mid_i] <= vert_ptr[12:0];
            tbl_tbase[mid_i] <= tri_ptr[12:0];
            tbl_tcnt[mid_i]  <= tcnt;
        end
    end

    // Command parser FSM with registered write strobes and scene state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd         <= C_LOAD;
            sect        <= SEC_VERT;
            hdr_cnt     <= '0;
            mid         <= '0;
            vcnt        <= '0;
            tcnt        <= '0;
            target      <= '0;
            word_idx    <= '0;
            byte_idx    <= '0;
            disc_cnt    <= '0;
            shift       <= '0;
            vert_ptr    <= '0;
            tri_ptr     <= '0;
            next_inst   <= 9'd1;
            tbl_valid   <= '0;
            in_ready    <= 1'b1;
            vert_we     <= 1'b0;
            vert_waddr  <= '0;
            vert_wdata  <= '0;
            tri_we      <= 1'b0;
            tri_waddr   <= '0;
            tri_wdata   <= '0;
            inst_we     <= 1'b0;
            inst_waddr  <= '0;
            inst_wdata  <= '0;
            xf_we       <= 1'b0;
            xf_waddr    <= '0;
            xf_wdata    <= '0;
            max_inst    <= '0;
            create_done <= 1'b0;
            err         <= 1'b0;
        end else begin
            // NOTE: strobes default low here so any write pulses exactly one cycle.
            vert_we <= 1'b0;
            tri_we  <= 1'b0;
            inst_we <= 1'b0;
            xf_we   <= 1'b0;
            case (state)
                S_IDLE: if (accept) begin
                    hdr_cnt  <= '0;
                    word_idx <= '0;
                    byte_idx <= '0;
                    case (in_data)
                        OP_LOAD: begin
                            cmd   <= C_LOAD;
                            state <= S_HDR;
                        end
                        OP_CREATE: begin
                            cmd   <= C_CREATE;
                            state <= S_HDR;
                        end
                        OP_CAMERA: begin
                            cmd    <= C_CAMERA;
                            target <= 8'd0;
                            sect   <= SEC_XF;
                            state  <= S_PAYLOAD;
                        end
                        OP_UPDATE: begin
                            cmd   <= C_UPDATE;
                            state <= S_HDR;
                        end
                        OP_COMMIT: create_done <= 1'b1;
                        OP_CLEAR: begin
                            vert_ptr    <= '0;
                            tri_ptr     <= '0;
                            next_inst   <= 9'd1;
                            max_inst    <= '0;
                            tbl_valid   <= '0;
                            create_done <= 1'b0;
                            err         <= 1'b0;
                        end
                        default: err <= 1'b1;
                    endcase
                end
                S_HDR: if (accept) begin
                    hdr_cnt <= hdr_cnt + 2'd1;
                    case (cmd)
                        C_LOAD: begin
                            case (hdr_cnt)
                                2'd0: mid  <= in_data;
                                2'd1: vcnt <= in_data;
                                default: begin
                                    tcnt <= in_data;
                                    sect <= SEC_VERT;
                                    if (load_bad) begin
                                        err      <= 1'b1;
                                        disc_cnt <= load_bytes;
                                        state    <= (load_bytes == '0) ? S_IDLE : S_DISCARD;
                                    end else begin
                                        state <= S_PAYLOAD;
                                    end
                                end
                            endcase
                        end
                        C_CREATE: begin
                            mid    <= in_data;
                            target <= next_inst[7:0];
                            sect   <= SEC_XF;
                            if (create_bad) begin
                                err      <= 1'b1;
                                disc_cnt <= DC_W'(XF_BYTES);
                                state    <= S_DISCARD;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                        default: begin
                            target <= in_data;
                            sect   <= SEC_XF;
                            if (update_bad) begin
                                err      <= 1'b1;
                                disc_cnt <= DC_W'(XF_BYTES);
                                state    <= S_DISCARD;
                            end else begin
                                state <= S_PAYLOAD;
                            end
                        end
                    endcase
                end
                S_PAYLOAD: if (accept) begin
                    shift <= shift_next;
                    if (byte_idx == sect_last) begin
                        byte_idx <= '0;
                        in_ready <= 1'b0;
                        state    <= S_WRITE;
                        case (sect)
                            SEC_VERT: begin
                                vert_we    <= 1'b1;
                                vert_waddr <= vert_ptr[12:0] + 13'(word_idx);
                                vert_wdata <= shift_next[VTX_W-1:0];
                            end
                            SEC_TRI: begin
                                tri_we    <= 1'b1;
                                tri_waddr <= tri_ptr[12:0] + 13'(word_idx);
                                tri_wdata <= shift_next[TRI_W-1:0];
                                if (tri_bad) err <= 1'b1;
                            end
                            default: begin
                                xf_we    <= 1'b1;
                                xf_waddr <= target;
                                xf_wdata <= shift_next[XF_W-1:0];
                                if (cmd == C_CREATE) begin
                                    inst_we    <= 1'b1;
                                    inst_waddr <= target;
                                    inst_wdata <= {tbl_vbase[mid_i], tbl_tbase[mid_i], tbl_tcnt[mid_i]};
                                end
                            end
                        endcase
                    end else begin
                        byte_idx <= byte_idx + 1'b1;
                    end
                end
                S_WRITE: begin
                    in_ready <= 1'b1;
                    state    <= S_PAYLOAD;
                    case (sect)
                        SEC_VERT: begin
                            if (word_last) begin
                                sect     <= SEC_TRI;
                                word_idx <= '0;
                            end else begin
                                word_idx <= word_idx + 8'd1;
                            end
                        end
                        SEC_TRI: begin
                            if (word_last) begin
                                tbl_valid[mid_i] <= 1'b1;
                                vert_ptr         <= vert_ptr + PTR_W'(vcnt);
                                tri_ptr          <= tri_ptr + PTR_W'(tcnt);
                                state            <= S_IDLE;
                            end else begin
                                word_idx <= word_idx + 8'd1;
                            end
                        end
                        default: begin
                            if (cmd == C_CREATE) begin
                                max_inst  <= target;
                                next_inst <= next_inst + 9'd1;
                            end
                            state <= S_IDLE;
                        end
                    endcase
                end
                S_DISCARD: if (accept) begin
                    disc_cnt <= disc_cnt - 1'b1;
                    if (disc_cnt == DC_W'(1)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_scene_loader.sv
// tb_scene_loader: packet-level reference model plus write scoreboard for
// scene_loader. Stimulus pushes expected RAM writes; a negedge monitor pops
// and compares them whenever the DUT raises a write strobe.
module tb_scene_loader;
    localparam int VTX_W     = 108;
    localparam int XF_W      = 288;
    localparam int VTX_BYTES = 14;
    localparam int XF_BYTES  = 36;
    localparam logic [287:0] VMASK = (288'(1) << VTX_W) - 288'(1);

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [7:0]   in_data;
    logic         in_ready;
    logic         vert_we;
    logic [12:0]  vert_waddr;
    logic [107:0] vert_wdata;
    logic         tri_we;
    logic [12:0]  tri_waddr;
    logic [23:0]  tri_wdata;
    logic         inst_we;
    logic [7:0]   inst_waddr;
    logic [33:0]  inst_wdata;
    logic         xf_we;
    logic [7:0]   xf_waddr;
    logic [287:0] xf_wdata;
    logic [7:0]   max_inst;
    logic         create_done;
    logic         err;

    scene_loader dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .vert_we(vert_we), .vert_waddr(vert_waddr), .vert_wdata(vert_wdata),
        .tri_we(tri_we), .tri_waddr(tri_waddr), .tri_wdata(tri_wdata),
        .inst_we(inst_we), .inst_waddr(inst_waddr), .inst_wdata(inst_wdata),
        .xf_we(xf_we), .xf_waddr(xf_waddr), .xf_wdata(xf_wdata),
        .max_inst(max_inst), .create_done(create_done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           kind;   // 0 vertex, 1 triangle, 2 instance, 3 transform
        int           addr;
        logic [287:0] data;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pkt[$];
    int         checks   = 0;
    int         failures = 0;
    int         gap_mode = 0;

    // Reference scene state.
    int m_vptr, m_tptr, m_next, m_max;
    bit m_err, m_done;
    int t_vbase[16], t_tbase[16], t_tcnt[16];
    bit t_valid[16];

    task automatic check(input string name, input logic [287:0] act, input logic [287:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_vptr = 0; m_tptr = 0; m_next = 1; m_max = 0; m_err = 0; m_done = 0;
        for (int i = 0; i < 16; i++) t_valid[i] = 0;
    endtask

    function automatic logic [287:0] pack_bytes(input int first, input int n);
        logic [287:0] w = '0;
        for (int i = 0; i < n; i++) w = (w << 8) | 288'(pkt[first + i]);
        return w;
    endfunction

    function automatic ev_t mk(input int kind, input int addr, input logic [287:0] data);
        ev_t e;
        e.kind = kind; e.addr = addr; e.data = data;
        return e;
    endfunction

    // Apply one whole packet to the reference model, queueing expected writes.
    task automatic model_pkt();
        int op = int'(pkt[0]);
        case (op)
            'hA1: begin
                int mid = int'(pkt[1]);
                int vc  = int'(pkt[2]);
                int tc  = int'(pkt[3]);
                if (mid >= 16 || vc == 0 || tc == 0 || m_vptr + vc > 8192 || m_tptr + tc > 8192) begin
                    m_err = 1;
                end else begin
                    for (int i = 0; i < vc; i++)
                        exp_q.push_back(mk(0, m_vptr + i, pack_bytes(4 + VTX_BYTES * i, VTX_BYTES) & VMASK));
                    for (int j = 0; j < tc; j++) begin
                        int b = 4 + VTX_BYTES * vc + 3 * j;
                        if (int'(pkt[b]) >= vc || int'(pkt[b+1]) >= vc || int'(pkt[b+2]) >= vc) m_err = 1;
                        exp_q.push_back(mk(1, m_tptr + j, pack_bytes(b, 3)));
                    end
                    t_vbase[mid] = m_vptr; t_tbase[mid] = m_tptr; t_tcnt[mid] = tc; t_valid[mid] = 1;
                    m_vptr += vc; m_tptr += tc;
                end
            end
            'hA2: begin
                int mid = int'(pkt[1]);
                if (mid >= 16 || m_next == 256) m_err = 1;
                else if (!t_valid[mid]) m_err = 1;
                else begin
                    exp_q.push_back(mk(2, m_next, (288'(t_vbase[mid]) << 21) |
                                                  (288'(t_tbase[mid]) << 8) | 288'(t_tcnt[mid])));
                    exp_q.push_back(mk(3, m_next, pack_bytes(2, XF_BYTES)));
                    m_max = m_next;
                    m_next++;
                end
            end
            'hA3: exp_q.push_back(mk(3, 0, pack_bytes(1, XF_BYTES)));
            'hA4: begin
                int id = int'(pkt[1]);
                if (id == 0 || id > m_max) m_err = 1;
                else exp_q.push_back(mk(3, id, pack_bytes(2, XF_BYTES)));
            end
            'hA5: m_done = 1;
            'hA6: begin
                m_vptr = 0; m_tptr = 0; m_next = 1; m_max = 0; m_done = 0; m_err = 0;
                for (int i = 0; i < 16; i++) t_valid[i] = 0;
            end
            default: m_err = 1;
        endcase
    endtask

    // Packet builders.
    task automatic build_load(input int mid, input int vc, input int tc, input bit bad);
        pkt.delete();
        pkt.push_back(8'hA1); pkt.push_back(8'(mid)); pkt.push_back(8'(vc)); pkt.push_back(8'(tc));
        for (int i = 0; i < VTX_BYTES * vc; i++) pkt.push_back(8'($urandom_range(0, 255)));
        for (int j = 0; j < 3 * tc; j++) begin
            if (vc > 0 && !bad) pkt.push_back(8'($urandom_range(0, vc - 1)));
            else pkt.push_back(8'($urandom_range(0, 255)));
        end
    endtask

    task automatic build_xf(input logic [7:0] op, input int arg, input bit has_arg);
        pkt.delete();
        pkt.push_back(op);
        if (has_arg) pkt.push_back(8'(arg));
        for (int i = 0; i < XF_BYTES; i++) pkt.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic build_byte(input logic [7:0] b);
        pkt.delete();
        pkt.push_back(b);
    endtask

    // Drive the first 'limit' bytes of pkt, honouring in_ready with a bounded wait.
    task automatic send_pkt(input int limit);
        for (int i = 0; i < limit; i++) begin
            int n = 0;
            in_valid = 1'b1;
            in_data  = pkt[i];
            @(negedge clk);
            while (!in_ready && n < 8) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                checks++; failures++;
                $display("FAIL in_ready_timeout: byte %0d still not accepted after %0d cycles", i, n);
            end
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (gap_mode == 1 || (gap_mode == 2 && $urandom_range(0, 3) == 0)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic check_status(input string tag);
        check({tag, "_err"}, 288'(err), 288'(m_err));
        check({tag, "_max_inst"}, 288'(max_inst), 288'(m_max));
        check({tag, "_create_done"}, 288'(create_done), 288'(m_done));
        check({tag, "_pending_writes"}, 288'(exp_q.size()), 288'(0));
    endtask

    task automatic do_pkt(input string tag);
        model_pkt();
        send_pkt(pkt.size());
        repeat (3) @(posedge clk);
        #1;
        check_status(tag);
    endtask

    task automatic expect_write(input int kind, input int addr, input logic [287:0] data);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_write: kind %0d addr %0d data %0h with nothing expected", kind, addr, data);
        end else begin
            e = exp_q.pop_front();
            check("write_kind", 288'(kind), 288'(e.kind));
            check("write_addr", 288'(addr), 288'(e.addr));
            check("write_data", data, e.data);
        end
    endtask

    // Monitor: every strobe must match the head of the scoreboard, and in_ready
    // must be low exactly in write cycles.
    always @(negedge clk) begin
        if (!rst) begin
            if (vert_we) expect_write(0, int'(vert_waddr), 288'(vert_wdata));
            if (tri_we)  expect_write(1, int'(tri_waddr), 288'(tri_wdata));
            if (inst_we) expect_write(2, int'(inst_waddr), 288'(inst_wdata));
            if (xf_we)   expect_write(3, int'(xf_waddr), xf_wdata);
            if (vert_we || tri_we || inst_we || xf_we || !in_ready)
                check("in_ready_write_cycle", 288'(in_ready),
                      288'(!(vert_we || tri_we || inst_we || xf_we)));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"}, 288'(in_ready), 288'(1));
        check({tag, "_strobes"}, 288'({vert_we, tri_we, inst_we, xf_we}), 288'(0));
        check({tag, "_max_inst"}, 288'(max_inst), 288'(0));
        check({tag, "_create_done"}, 288'(create_done), 288'(0));
        check({tag, "_err"}, 288'(err), 288'(0));
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        model_reset();
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single model with triangle {0,1,2}.
        build_load(0, 3, 1, 0);
        pkt[pkt.size()-3] = 8'h00; pkt[pkt.size()-2] = 8'h01; pkt[pkt.size()-1] = 8'h02;
        do_pkt("load0");

        // Instance of model 0, then commit.
        build_xf(8'hA2, 0, 1); do_pkt("create0");
        build_byte(8'hA5);     do_pkt("commit");

        // Second model lands after the first; instance gets its bases.
        build_load(1, 4, 2, 0); do_pkt("load1");
        build_xf(8'hA2, 1, 1);  do_pkt("create1");

        // Byte gaps every other cycle while streaming a vertex.
        gap_mode = 1;
        build_load(2, 1, 1, 0); do_pkt("gapped");
        gap_mode = 0;

        // Create on an empty table is discarded; camera still works afterwards.
        build_byte(8'hA6);      do_pkt("clear");
        build_xf(8'hA2, 5, 1);  do_pkt("create_empty");
        build_xf(8'hA3, 0, 0);  do_pkt("camera");

        // Unknown opcode.
        build_byte(8'h7F);      do_pkt("unknown");

        // Reset in the middle of a vertex payload.
        build_byte(8'hA6);      do_pkt("clear2");
        build_load(0, 2, 1, 0); do_pkt("load_pre");
        build_xf(8'hA2, 0, 1);  do_pkt("create_pre");
        build_load(1, 2, 1, 0);
        model_pkt();
        send_pkt(4 + VTX_BYTES + 5);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        build_load(3, 2, 2, 0); do_pkt("load_after_reset");

        // Header error cases with all bytes still consumed.
        build_load(16, 1, 1, 0); do_pkt("load_mid_oob");
        build_load(4, 0, 2, 0);  do_pkt("load_vcnt0");
        build_load(4, 2, 1, 1);  do_pkt("load_bad_index");
        build_xf(8'hA4, 0, 1);   do_pkt("update_id0");

        // Randomised packet mix with random byte gaps.
        gap_mode = 2;
        for (int k = 0; k < 60; k++) begin
            int r = $urandom_range(0, 99);
            if (r < 35) build_load($urandom_range(0, 17), $urandom_range(0, 4),
                                   $urandom_range(0, 3), ($urandom_range(0, 9) == 0));
            else if (r < 60) build_xf(8'hA2, $urandom_range(0, 17), 1);
            else if (r < 75) build_xf(8'hA4, $urandom_range(0, m_max + 1), 1);
            else if (r < 82) build_xf(8'hA3, 0, 0);
            else if (r < 88) build_byte(8'hA5);
            else if (r < 93) build_byte(8'hA6);
            else begin
                case ($urandom_range(0, 3))
                    0: build_byte(8'h00);
                    1: build_byte(8'hA0);
                    2: build_byte(8'hA7);
                    default: build_byte(8'hFF);
                endcase
            end
            do_pkt("random");
        end
        gap_mode = 0;

        // Fill the instance table up to id 255; the next create must fail.
        build_byte(8'hA6);      do_pkt("clear3");
        build_load(0, 1, 1, 0); do_pkt("load_cap");
        for (int k = 0; k < 255; k++) begin
            build_xf(8'hA2, 0, 1);
            model_pkt();
            send_pkt(pkt.size());
        end
        repeat (3) @(posedge clk);
        #1;
        check_status("create_255");
        build_xf(8'hA2, 0, 1);   do_pkt("create_full");
        build_xf(8'hA4, 255, 1); do_pkt("update_255");

        check("final_pending_writes", 288'(exp_q.size()), 288'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
